// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter that shares the single SRAM controller
// port among N_REQ masters. Exactly one access is in flight at a time. Every
// command and address output is registered and driven to 0 outside ACCESS.
// Optional feature macro: SRAM_TIMEOUT_EN. It aborts an access that has waited
// TIMEOUT_CYC cycles in ACCESS and flags err together with the ack.
module sram_arbiter #(
  parameter int N_REQ       = 2,
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       rdata,
  output logic                    err,
  input  logic                    sram_idle,
  input  logic                    sram_ready,
  input  logic [DATA_W-1:0]       data_in,
  output logic [ADDR_W-1:0]       data_addr,
  output logic [DATA_W-1:0]       data_out,
  output logic                    read_data,
  output logic                    write_data,
  output logic [1:0]              arb_state
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_IDLE = 2'd1,
    ACCESS    = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [IDX_W-1:0]   lat_idx, lat_idx_d;
  logic               lat_we, lat_we_d;
  logic [ADDR_W-1:0]  lat_addr, lat_addr_d;
  logic [DATA_W-1:0]  lat_wdata, lat_wdata_d;
  logic [N_REQ-1:0]   ack_d;
  logic [DATA_W-1:0]  rdata_d;
  logic [ADDR_W-1:0]  data_addr_d;
  logic [DATA_W-1:0]  data_out_d;
  logic               read_data_d, write_data_d;

`ifdef SRAM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
`endif

  assign arb_state = state;

  // Winner search: first set request found scanning upward from the
  // round-robin pointer, wrapping modulo N_REQ.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Next-state logic plus the next values of every registered output.
  always_comb begin
    state_d     = state;
    lat_idx_d   = lat_idx;
    lat_we_d    = lat_we;
    lat_addr_d  = lat_addr;
    lat_wdata_d = lat_wdata;
    rr_ptr_d    = rr_ptr;
    rdata_d     = rdata;
`ifdef SRAM_TIMEOUT_EN
    tmo_hit     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (win_found) begin
          lat_idx_d   = win_idx;
          lat_we_d    = req_we[win_idx];
          lat_addr_d  = req_addr[win_idx*ADDR_W +: ADDR_W];
          lat_wdata_d = req_wdata[win_idx*DATA_W +: DATA_W];
          state_d     = sram_idle ? ACCESS : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (sram_idle) state_d = ACCESS;
      end
      ACCESS: begin
        if (sram_ready) begin
          if (!lat_we) rdata_d = data_in;
          state_d = DONE;
        end
`ifdef SRAM_TIMEOUT_EN
        else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          tmo_hit = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        rr_ptr_d = (lat_idx == IDX_W'(N_REQ - 1)) ? '0 : lat_idx + IDX_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ack_d        = '0;
    data_addr_d  = '0;
    data_out_d   = '0;
    read_data_d  = 1'b0;
    write_data_d = 1'b0;
    if (state_d == ACCESS) begin
      data_addr_d  = lat_addr_d;
      data_out_d   = lat_wdata_d;
      read_data_d  = ~lat_we_d;
      write_data_d = lat_we_d;
    end
    if (state_d == DONE) ack_d[lat_idx_d] = 1'b1;
  end

  // State register, request latches and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      lat_idx    <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      ack        <= '0;
      rdata      <= '0;
      data_addr  <= '0;
      data_out   <= '0;
      read_data  <= 1'b0;
      write_data <= 1'b0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_ptr_d;
      lat_idx    <= lat_idx_d;
      lat_we     <= lat_we_d;
      lat_addr   <= lat_addr_d;
      lat_wdata  <= lat_wdata_d;
      ack        <= ack_d;
      rdata      <= rdata_d;
      data_addr  <= data_addr_d;
      data_out   <= data_out_d;
      read_data  <= read_data_d;
      write_data <= write_data_d;
    end
  end

`ifdef SRAM_TIMEOUT_EN
  // Access watchdog: counts cycles spent in ACCESS, restarts on every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      tmo_cnt <= (state == ACCESS) ? tmo_cnt + CNT_W'(1) : '0;
      err     <= tmo_hit;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter.
// Contention and single-read traces come from a cycle table. Idle wait,
// request drop, reset and timeout are covered by hand-written sequences.
module tb_sram_arbiter;

  localparam int N  = 2;
  localparam int AW = 21;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req, req_we;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wd0, wd1;
  logic [N-1:0]  ack;
  logic [DW-1:0] rdata;
  logic          err;
  logic          sram_idle, sram_ready;
  logic [DW-1:0] data_in;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_out;
  logic          read_data, write_data;
  logic [1:0]    arb_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req(req), .req_we(req_we),
    .req_addr({addr1, addr0}), .req_wdata({wd1, wd0}),
    .ack(ack), .rdata(rdata), .err(err),
    .sram_idle(sram_idle), .sram_ready(sram_ready), .data_in(data_in),
    .data_addr(data_addr), .data_out(data_out),
    .read_data(read_data), .write_data(write_data), .arb_state(arb_state)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [20:0] a0;
    logic [20:0] a1;
    logic        idle;
    logic        ready;
    logic [15:0] din;
    logic [1:0]  st;
    logic [1:0]  ack;
    logic        rd;
    logic        wr;
    logic [20:0] addr;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] r, logic [1:0] w, logic [20:0] a0, logic [20:0] a1,
                              logic idl, logic rdy, logic [15:0] din, logic [1:0] st,
                              logic [1:0] ak, logic rd, logic wr, logic [20:0] ad,
                              logic [15:0] rdt);
    vec_t v;
    v.req = r; v.we = w; v.a0 = a0; v.a1 = a1; v.idle = idl; v.ready = rdy; v.din = din;
    v.st = st; v.ack = ak; v.rd = rd; v.wr = wr; v.addr = ad; v.rdata = rdt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    req = v.req; req_we = v.we; addr0 = v.a0; addr1 = v.a1;
    wd0 = '0; wd1 = '0;
    sram_idle = v.idle; sram_ready = v.ready; data_in = v.din;
    cycle();
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    reset_n = 1'b0;
    req = '0; req_we = '0; addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
    sram_idle = 1'b0; sram_ready = 1'b0; data_in = '0;
    #12;
    checkOutput("reset state", 32'(arb_state), 0);
    checkOutput("reset ack", 32'(ack), 0);
    checkOutput("reset rdata", 32'(rdata), 0);
    checkOutput("reset cmds", 32'({read_data, write_data, err}), 0);
    checkOutput("reset addr", 32'(data_addr), 0);
    reset_n = 1'b1;

    // contention: both masters reading, grants alternate 0,1,0,1
    vecs.push_back(mk(2'b11, 2'b00, 21'h100, 21'h200, 1, 1, 16'hA001, 2, 2'b00, 1, 0, 21'h100, 16'h0000));
    vecs.push_back(mk(2'b11, 2'b00, 21'h100, 21'h200, 1, 1, 16'hA002, 3, 2'b01, 0, 0, 21'h0,   16'hA002));
    vecs.push_back(mk(2'b11, 2'b00, 21'h100, 21'h200, 1, 1, 16'hA003, 0, 2'b00, 0, 0, 21'h0,   16'hA002));
    vecs.push_back(mk(2'b11, 2'b00, 21'h100, 21'h200, 1, 1, 16'hA004, 2, 2'b00, 1, 0, 21'h200, 16'hA002));
    vecs.push_back(mk(2'b11, 2'b00, 21'h100, 21'h200, 1, 1, 16'hA005, 3, 2'b10, 0, 0, 21'h0,   16'hA005));
    vecs.push_back(mk(2'b11, 2'b00, 21'h100, 21'h200, 1, 1, 16'hA006, 0, 2'b00, 0, 0, 21'h0,   16'hA005));
    vecs.push_back(mk(2'b11, 2'b00, 21'h100, 21'h200, 1, 1, 16'hA007, 2, 2'b00, 1, 0, 21'h100, 16'hA005));
    vecs.push_back(mk(2'b11, 2'b00, 21'h100, 21'h200, 1, 1, 16'hA008, 3, 2'b01, 0, 0, 21'h0,   16'hA008));
    vecs.push_back(mk(2'b11, 2'b00, 21'h100, 21'h200, 1, 1, 16'hA009, 0, 2'b00, 0, 0, 21'h0,   16'hA008));
    vecs.push_back(mk(2'b11, 2'b00, 21'h100, 21'h200, 1, 1, 16'hA00A, 2, 2'b00, 1, 0, 21'h200, 16'hA008));
    vecs.push_back(mk(2'b11, 2'b00, 21'h100, 21'h200, 1, 1, 16'hA00B, 3, 2'b10, 0, 0, 21'h0,   16'hA00B));
    vecs.push_back(mk(2'b00, 2'b00, 21'h100, 21'h200, 1, 0, 16'h0000, 0, 2'b00, 0, 0, 21'h0,   16'hA00B));
    // single read from master 1, ready two cycles after the request
    vecs.push_back(mk(2'b10, 2'b00, 21'h0, 21'h00A, 1, 0, 16'h0000, 2, 2'b00, 1, 0, 21'h00A, 16'hA00B));
    vecs.push_back(mk(2'b10, 2'b00, 21'h0, 21'h00A, 1, 0, 16'h5555, 2, 2'b00, 1, 0, 21'h00A, 16'hA00B));
    vecs.push_back(mk(2'b10, 2'b00, 21'h0, 21'h00A, 1, 1, 16'h8123, 3, 2'b10, 0, 0, 21'h0,   16'h8123));
    vecs.push_back(mk(2'b00, 2'b00, 21'h0, 21'h00A, 1, 0, 16'h0000, 0, 2'b00, 0, 0, 21'h0,   16'h8123));
    vecs.push_back(mk(2'b00, 2'b00, 21'h0, 21'h00A, 1, 1, 16'hFFFF, 0, 2'b00, 0, 0, 21'h0,   16'h8123));

    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      checkOutput($sformatf("v%0d state", k), 32'(arb_state), 32'(vecs[k].st));
      checkOutput($sformatf("v%0d ack", k), 32'(ack), 32'(vecs[k].ack));
      checkOutput($sformatf("v%0d read_data", k), 32'(read_data), 32'(vecs[k].rd));
      checkOutput($sformatf("v%0d write_data", k), 32'(write_data), 32'(vecs[k].wr));
      checkOutput($sformatf("v%0d data_addr", k), 32'(data_addr), 32'(vecs[k].addr));
      checkOutput($sformatf("v%0d rdata", k), 32'(rdata), 32'(vecs[k].rdata));
    end

    // write from master 0 while the controller stays busy for 5 cycles
    req = 2'b01; req_we = 2'b01; addr0 = 21'h1FFFFF; wd0 = 16'h7FFF;
    sram_idle = 1'b0; sram_ready = 1'b0; data_in = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checkOutput($sformatf("wait%0d state", i), 32'(arb_state), 1);
      checkOutput($sformatf("wait%0d write_data", i), 32'(write_data), 0);
      checkOutput($sformatf("wait%0d data_out", i), 32'(data_out), 0);
    end
    sram_idle = 1'b1;
    cycle();
    checkOutput("wr state", 32'(arb_state), 2);
    checkOutput("wr cmds", 32'({read_data, write_data}), 32'b01);
    checkOutput("wr data_addr", 32'(data_addr), 32'h1FFFFF);
    checkOutput("wr data_out", 32'(data_out), 32'h7FFF);
    sram_ready = 1'b1;
    cycle();
    checkOutput("wr ack", 32'(ack), 32'b01);
    checkOutput("wr rdata kept", 32'(rdata), 32'h8123);
    checkOutput("wr data_out done", 32'(data_out), 0);
    req = '0; sram_ready = 1'b0;
    cycle();
    checkOutput("wr back idle", 32'(arb_state), 0);

    // master 1 drops its request right after being latched
    req = 2'b10; req_we = 2'b00; addr1 = 21'h042;
    cycle();
    checkOutput("drop access", 32'(arb_state), 2);
    req = '0;
    cycle();
    checkOutput("drop still access", 32'(arb_state), 2);
    checkOutput("drop data_addr", 32'(data_addr), 32'h042);
    sram_ready = 1'b1; data_in = 16'h0BEE;
    cycle();
    checkOutput("drop ack", 32'(ack), 32'b10);
    checkOutput("drop rdata", 32'(rdata), 32'h0BEE);
    sram_ready = 1'b0;
    cycle();
    checkOutput("drop ack once", 32'(ack), 0);
    cycle();
    checkOutput("drop no reack", 32'(ack), 0);

    // asynchronous reset in the middle of a write access
    req = 2'b01; req_we = 2'b01; addr0 = 21'h055; wd0 = 16'h0066;
    cycle();
    checkOutput("rst pre access", 32'({arb_state, write_data}), 32'b101);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("rst mid state", 32'(arb_state), 0);
    checkOutput("rst mid cmds", 32'({read_data, write_data, err}), 0);
    checkOutput("rst mid addr", 32'(data_addr), 0);
    checkOutput("rst mid data_out", 32'(data_out), 0);
    checkOutput("rst mid rdata", 32'(rdata), 0);
    req = '0;
    #2 reset_n = 1'b1;
    sram_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (ack !== '0 || arb_state !== 2'd0) bad++;
    end
    checkOutput("rst no ack after release", 32'(bad), 0);

    // controller never reports ready
    sram_ready = 1'b0; data_in = 16'hDEAD;
    req = 2'b01; req_we = 2'b00; addr0 = 21'h077;
    cycle();
    checkOutput("tmo enter access", 32'(arb_state), 2);
    req = '0;
`ifdef SRAM_TIMEOUT_EN
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (arb_state !== 2'd2 || err !== 1'b0 || ack !== '0) bad++;
    end
    checkOutput("tmo waiting cycles", 32'(bad), 0);
    cycle();
    checkOutput("tmo ack", 32'(ack), 32'b01);
    checkOutput("tmo err", 32'(err), 1);
    checkOutput("tmo rdata kept", 32'(rdata), 0);
    cycle();
    checkOutput("tmo err cleared", 32'({err, ack}), 0);
`else
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      if (arb_state !== 2'd2 || err !== 1'b0 || ack !== '0 || read_data !== 1'b1) bad++;
    end
    checkOutput("stuck in access bad cycles", 32'(bad), 0);
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
